// File: rtl/proc_mem_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// FSM states, access owners, default parameter values.
package proc_mem_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 8;
  localparam int WAIT_CYC_DEF   = 1;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DMA
  } owner_t;

endpackage

// File: rtl/data_mem_arb_stats.sv
// Grant counters for the data-memory arbiter (wrap at 16 bits).
// Ports: clk, rst_n, cpu_grant/dma_grant pulses in, two 16-bit counts out.
module data_mem_arb_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_grant,
  input  logic        dma_grant,
  output logic [15:0] cpu_grant_cnt,
  output logic [15:0] dma_grant_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_grant_cnt <= '0;
      dma_grant_cnt <= '0;
    end else begin
      if (cpu_grant)
        cpu_grant_cnt <= cpu_grant_cnt + 16'd1;
      if (dma_grant)
        dma_grant_cnt <= dma_grant_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data RAM arbiter: MEM-stage CPU port vs image DMA loader.
// Ports: clk, rst_n; cpu_* (re/we/addr/wdata/rdata/done/stall);
// dma_* (req/we/addr/wdata/rdata/ack); mem_* RAM side.
// DATA_MEM_ARB_STATS_EN adds cpu_grant_cnt/dma_grant_cnt outputs.
module data_mem_arbiter
  import proc_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int WAIT_CYC   = WAIT_CYC_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DATA_MEM_ARB_STATS_EN
  ,
  output logic [15:0]       cpu_grant_cnt,
  output logic [15:0]       dma_grant_cnt
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t        state;
  state_t        state_nx;
  owner_t        owner;
  logic          op_we;
  logic [3:0]    wait_cnt;
  logic [SW-1:0] starve_cnt;
  logic          cpu_req;
  logic          dma_win;
  logic          grant_cpu;
  logic          grant_dma;
  logic          rd_last;

  assign cpu_req   = cpu_re | cpu_we;
  assign cpu_stall = cpu_req & ~cpu_done;

  // DMA takes the slot when the CPU is quiet or has starved it.
  assign dma_win   = dma_req
                   & (~cpu_req
                   | (starve_cnt == SW'(STARVE_MAX)));
  assign grant_dma = (state == IDLE) & dma_win;
  assign grant_cpu = (state == IDLE) & cpu_req & ~dma_win;

  // Last WAIT cycle is the one where mem_rdata is valid.
  assign rd_last   = (state == WAIT) & (wait_cnt == 4'd1);

  always_comb begin
    state_nx = state;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    cpu_done = 1'b0;
    dma_ack  = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_cpu | grant_dma)
          state_nx = ACCESS;
      end
      ACCESS: begin
        mem_re   = ~op_we;
        mem_we   = op_we;
        state_nx = op_we ? RESP : WAIT;
      end
      WAIT: begin
        if (rd_last)
          state_nx = RESP;
      end
      RESP: begin
        cpu_done = (owner == OWN_CPU);
        dma_ack  = (owner == OWN_DMA);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      op_we      <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      state <= state_nx;
      if (grant_dma) begin
        owner     <= OWN_DMA;
        op_we     <= dma_we;
        mem_addr  <= dma_addr;
        mem_wdata <= dma_wdata;
      end else if (grant_cpu) begin
        // re & we together is taken as a store
        owner     <= OWN_CPU;
        op_we     <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end
      if (grant_dma | ~dma_req)
        starve_cnt <= '0;
      else if (grant_cpu
               && starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
      if (state == ACCESS && !op_we)
        wait_cnt <= 4'(WAIT_CYC);
      else if (state == WAIT)
        wait_cnt <= wait_cnt - 1'b1;
      if (rd_last) begin
        if (owner == OWN_DMA)
          dma_rdata <= mem_rdata;
        else
          cpu_rdata <= mem_rdata;
      end
    end
  end

`ifdef DATA_MEM_ARB_STATS_EN
  data_mem_arb_stats u_stats (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_grant     (grant_cpu),
    .dma_grant     (grant_dma),
    .cpu_grant_cnt (cpu_grant_cnt),
    .dma_grant_cnt (dma_grant_cnt)
  );
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: RAM model plus
// transaction-level reference memory and arbitration expectations.
module tb_data_mem_arbiter;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 8;
  localparam int WAIT_CYC   = 1;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cpu_re = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_stall;
  logic              dma_req = 1'b0;
  logic              dma_we = 1'b0;
  logic [ADDR_W-1:0] dma_addr = '0;
  logic [DATA_W-1:0] dma_wdata = '0;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata = '0;
`ifdef DATA_MEM_ARB_STATS_EN
  logic [15:0]       cpu_grant_cnt;
  logic [15:0]       dma_grant_cnt;
`endif

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .WAIT_CYC   (WAIT_CYC),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_rdata (dma_rdata),
    .dma_ack   (dma_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
`ifdef DATA_MEM_ARB_STATS_EN
    ,
    .cpu_grant_cnt (cpu_grant_cnt),
    .dma_grant_cnt (dma_grant_cnt)
`endif
  );

  // RAM contents seen by the DUT, and the bench's expected contents.
  logic [7:0] ram     [0:255];
  logic [7:0] ref_mem [0:255];
  int         rd_cnt = 0;
  logic [7:0] rd_data = '0;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] last_cpu_rd = '0;
  logic [7:0] last_dma_rd = '0;

  // RAM model: data valid only in the cycle WAIT_CYC after the read strobe.
  always @(posedge clk) begin
    logic       re_s;
    logic       we_s;
    logic [7:0] a_s;
    logic [7:0] d_s;
    re_s = mem_re;
    we_s = mem_we;
    a_s  = mem_addr[7:0];
    d_s  = mem_wdata;
    #1;
    if (rd_cnt > 0) rd_cnt = rd_cnt - 1;
    if (re_s) begin
      rd_cnt  = WAIT_CYC;
      rd_data = ram[a_s];
    end
    if (we_s) ram[a_s] = d_s;
    mem_rdata = (rd_cnt == 1) ? rd_data : 8'($urandom);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle.
  task automatic do_access(input bit is_dma, input bit re,
                           input bit we, input logic [15:0] addr,
                           input logic [7:0] wdata,
                           input bit drop_early);
    int strobes;
    int strobe_cyc;
    int done_cyc;
    int exp_done;
    bit wr;
    logic done;
    logic other;
    logic [7:0] exp_rd;
    strobes    = 0;
    strobe_cyc = -1;
    done_cyc   = -1;
    wr         = we;
    exp_done   = wr ? 2 : 2 + WAIT_CYC;
    exp_rd     = ref_mem[addr[7:0]];
    if (wr) ref_mem[addr[7:0]] = wdata;
    if (is_dma) begin
      dma_req = 1'b1; dma_we = we;
      dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_re = re; cpu_we = we;
      cpu_addr = addr; cpu_wdata = wdata;
    end
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      #1;
      if (mem_re | mem_we) begin
        strobes++;
        strobe_cyc = c;
        chk("strobe_we", mem_we, wr);
        chk("strobe_re", mem_re, !wr);
        chk("mem_addr", mem_addr, addr);
        if (wr) chk("mem_wdata", mem_wdata, wdata);
      end
      if (!is_dma) chk("cpu_stall", cpu_stall, c < exp_done);
      done  = is_dma ? dma_ack : cpu_done;
      other = is_dma ? cpu_done : dma_ack;
      chk("other_done", other, 0);
      if (done) begin
        done_cyc = c;
        if (is_dma) begin
          chk("dma_rdata", dma_rdata, wr ? last_dma_rd : exp_rd);
          chk("cpu_rd_hold", cpu_rdata, last_cpu_rd);
          if (!wr) last_dma_rd = exp_rd;
        end else begin
          chk("cpu_rdata", cpu_rdata, wr ? last_cpu_rd : exp_rd);
          chk("dma_rd_hold", dma_rdata, last_dma_rd);
          if (!wr) last_cpu_rd = exp_rd;
        end
        cpu_re = 1'b0; cpu_we = 1'b0; dma_req = 1'b0;
      end
      if (drop_early && c == 1) dma_req = 1'b0;
      @(negedge clk);
    end
    cpu_re = 1'b0; cpu_we = 1'b0; dma_req = 1'b0;
    chk("done_cycle", done_cyc, exp_done);
    chk("strobe_count", strobes, 1);
    chk("strobe_cycle", strobe_cyc, 1);
    for (int k = 0; k < (drop_early ? 3 : 1); k++) begin
      #1;
      chk("quiet_after", {cpu_done, dma_ack, mem_re, mem_we}, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_done;
    bit  exp_dma;
    bit  r_dma;
    int  kind;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'(i * 37 + 11);
      ref_mem[i] = 8'(i * 37 + 11);
    end
    ram[16] = 8'h5A; ref_mem[16] = 8'h5A;
    #1 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_outs",
        {cpu_done, cpu_stall, dma_ack, mem_re, mem_we}, 0);
    chk("rst_data", {cpu_rdata, dma_rdata, mem_wdata}, 0);
    chk("rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // CPU load then store, then read back
    do_access(0, 1, 0, 16'h0010, 8'h00, 0);
    do_access(0, 0, 1, 16'h0020, 8'h33, 0);
    do_access(0, 1, 0, 16'h0020, 8'h00, 0);

    // DMA write dropping its request after the grant, then read back
    do_access(1, 0, 1, 16'h0030, 8'h77, 1);
    do_access(1, 0, 0, 16'h0030, 8'h00, 0);

    // Illegal decode: both strobes high is a store
    do_access(0, 1, 1, 16'h0040, 8'hC3, 0);
    do_access(0, 1, 0, 16'h0040, 8'h00, 0);

    // Both sides requesting continuously
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0011;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0012;
    n_done = 0;
    for (int c = 0; c < 200 && n_done < 10; c++) begin
      #1;
      if (cpu_done | dma_ack) begin
        exp_dma = (n_done % (STARVE_MAX + 1)) == STARVE_MAX;
        chk("starve_owner", dma_ack, exp_dma);
        chk("starve_both", cpu_done & dma_ack, 0);
        if (dma_ack)
          chk("starve_drd", dma_rdata, ref_mem[8'h12]);
        else
          chk("starve_crd", cpu_rdata, ref_mem[8'h11]);
        n_done++;
        if (n_done == 10) begin
          cpu_re = 1'b0; dma_req = 1'b0;
        end
      end
      @(negedge clk);
    end
    cpu_re = 1'b0; dma_req = 1'b0;
    chk("starve_count", n_done, 10);
    last_cpu_rd = ref_mem[8'h11];
    last_dma_rd = ref_mem[8'h12];
    @(negedge clk);

    // Randomized single-requester traffic
    for (int i = 0; i < 40; i++) begin
      r_dma = 1'($urandom);
      kind  = $urandom_range(0, 3);
      if (r_dma)
        do_access(1, 0, kind[0], 16'($urandom_range(0, 63)),
                  8'($urandom), 0);
      else
        do_access(0, kind != 2, kind >= 2,
                  16'($urandom_range(0, 63)), 8'($urandom), 0);
    end

    // Reset during the WAIT of a DMA read
    ram[8'h50] = 8'hA5; ref_mem[8'h50] = 8'hA5;
    do_access(1, 0, 0, 16'h0050, 8'h00, 0);
    ram[8'h51] = 8'h3C; ref_mem[8'h51] = 8'h3C;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0051;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_outs",
        {cpu_done, cpu_stall, dma_ack, mem_re, mem_we}, 0);
    chk("arst_data", {cpu_rdata, dma_rdata, mem_wdata}, 0);
    chk("arst_addr", mem_addr, 0);
    @(negedge clk);
    chk("arst_no_ack", {dma_ack, mem_re, mem_we}, 0);
    last_cpu_rd = '0;
    last_dma_rd = '0;
    rst_n = 1'b1;
    do_access(1, 0, 0, 16'h0051, 8'h00, 0);

`ifdef DATA_MEM_ARB_STATS_EN
    rst_n = 1'b0;
    @(negedge clk);
    chk("stats_rst", {cpu_grant_cnt, dma_grant_cnt}, 0);
    rst_n = 1'b1;
    last_cpu_rd = '0;
    last_dma_rd = '0;
    @(negedge clk);
    do_access(0, 1, 0, 16'h0001, 8'h00, 0);
    do_access(1, 0, 1, 16'h0002, 8'h44, 0);
    do_access(0, 0, 1, 16'h0003, 8'h55, 0);
    do_access(1, 0, 0, 16'h0004, 8'h00, 0);
    do_access(0, 1, 0, 16'h0005, 8'h00, 0);
    chk("stats_cpu", cpu_grant_cnt, 3);
    chk("stats_dma", dma_grant_cnt, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
